mem_arbiter: RTL and testbench

//  Shares the single 128-bit line data memory between the I-cache refill port (read-only)
//  and the D-cache refill/writeback port (read/write). Grants one line transaction at a time

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side line bus for mem_arbiter.
// The err signal exists only when ARB_TIMEOUT_EN is defined.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
);
    // I-cache refill port
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_ready;

    // D-cache refill / writeback port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_ready;

    // Line memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    logic                  busy;
`ifdef ARB_TIMEOUT_EN
    logic                  err;
`endif

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output busy
`ifdef ARB_TIMEOUT_EN
        , output err
`endif
    );

    // Cache and memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  busy
`ifdef ARB_TIMEOUT_EN
        , input err
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit line memory between the I-cache (read-only)
// and the D-cache (read/write). One line transaction at a time, round-robin on
// ties, IDLE -> ISSUE -> WAIT -> RESP sequencing of the one-shot memory handshake.
// Optional feature macro: ARB_TIMEOUT_EN adds a WAIT watchdog and the err output.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = 128,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t                 state_q, state_d;
    owner_t                 last_grant_q, owner_q, grant_sel;
    logic                   we_q;
    logic [ADDR_WIDTH-5:0]  addr_q;
    logic [LINE_WIDTH-1:0]  wdata_q;
    logic [LINE_WIDTH-1:0]  i_rdata_q;
    logic [LINE_WIDTH-1:0]  d_rdata_q;
    logic                   any_req;
    logic                   timeout_hit;

`ifdef ARB_TIMEOUT_EN
    logic [15:0]            wait_cnt_q, wait_cnt_d;
    logic                   timed_out_q;
`endif

    // Grant selection: a lone request wins; a tie goes to the port that did not win last
    always_comb begin
        any_req = bus.i_req | bus.d_req;
        if (bus.i_req && bus.d_req) begin
            grant_sel = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else if (bus.d_req) begin
            grant_sel = OWN_D;
        end else begin
            grant_sel = OWN_I;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog fires on the last WAIT cycle of the allowed window when memory stays silent
    always_comb begin
        timeout_hit = (state_q == WAIT) && !bus.mem_ready &&
                      (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
        wait_cnt_d  = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    // Watchdog counter and timeout flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            timed_out_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (state_q == ISSUE) begin
                timed_out_q <= 1'b0;
            end else if (timeout_hit) begin
                timed_out_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mem_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the latched transaction
    always_comb begin
        bus.mem_req   = (state_q == ISSUE);
        bus.mem_we    = we_q;
        bus.mem_addr  = {addr_q, 4'b0000};
        bus.mem_wdata = wdata_q;
        bus.i_ready   = (state_q == RESP) && (owner_q == OWN_I);
        bus.d_ready   = (state_q == RESP) && (owner_q == OWN_D);
        bus.i_rdata   = i_rdata_q;
        bus.d_rdata   = d_rdata_q;
        bus.busy      = (state_q != IDLE);
`ifdef ARB_TIMEOUT_EN
        bus.err       = (state_q == RESP) && timed_out_q;
`endif
    end

    // Transaction latch in IDLE and line-data capture in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= OWN_I;
            owner_q      <= OWN_I;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            if ((state_q == IDLE) && any_req) begin
                owner_q      <= grant_sel;
                last_grant_q <= grant_sel;
                if (grant_sel == OWN_D) begin
                    we_q    <= bus.d_we;
                    addr_q  <= bus.d_addr[ADDR_WIDTH-1:4];
                    wdata_q <= bus.d_wdata;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= bus.i_addr[ADDR_WIDTH-1:4];
                    wdata_q <= '0;
                end
            end
            if (state_q == WAIT) begin
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        if (owner_q == OWN_I) i_rdata_q <= bus.mem_rdata;
                        else                  d_rdata_q <= bus.mem_rdata;
                    end
                end else if (timeout_hit) begin
                    if (owner_q == OWN_I) i_rdata_q <= '0;
                    else                  d_rdata_q <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for mem_arbiter.
// Reference model tracks memory contents, round-robin history and per-port
// returned lines; each transaction is predicted as a fixed 4-cycle window.
// Define ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic spur = 1'b0;
    logic mem_silent = 1'b0;
    logic mem_ready_r = 1'b0;
    logic [127:0] mem_rdata_r = '0;
    logic [127:0] mem_store [16];
    logic [15:0]  mem_valid = '0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [127:0] ref_mem [16];
    logic [15:0]  ref_valid;
    logic [127:0] ref_i_rdata;
    logic [127:0] ref_d_rdata;
    int           last_g;

    mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH    (32),
        .LINE_WIDTH    (128),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Initial content of a memory line never written
    function automatic logic [127:0] line_pattern(input logic [3:0] idx);
        return {32'hA5A5_0000 | 32'(idx), 32'h5A5A_1000 | 32'(idx),
                32'h0F0F_2000 | 32'(idx), 32'hF0F0_3000 | 32'(idx)};
    endfunction

    // Line memory: one-cycle registered response to each mem_req
    always @(posedge clk) begin
        mem_ready_r <= 1'b0;
        if (bus.mem_req && !mem_silent) begin
            mem_ready_r <= 1'b1;
            if (bus.mem_we) begin
                mem_store[bus.mem_addr[7:4]] <= bus.mem_wdata;
                mem_valid[bus.mem_addr[7:4]] <= 1'b1;
            end else begin
                mem_rdata_r <= mem_valid[bus.mem_addr[7:4]] ? mem_store[bus.mem_addr[7:4]]
                                                            : line_pattern(bus.mem_addr[7:4]);
            end
        end
    end

    assign bus.mem_ready = mem_ready_r | spur;
    assign bus.mem_rdata = mem_rdata_r;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_read(input logic [31:0] a);
        return ref_valid[a[7:4]] ? ref_mem[a[7:4]] : line_pattern(a[7:4]);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'h0001_0000 | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
        return a;
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One arbitration round: starts just after a rising edge with the arbiter idle,
    // ends just after a rising edge with every request dropped.
    task automatic do_round(input bit ri, input bit rd, input logic [31:0] ia,
                            input logic [31:0] da, input bit dwe, input logic [127:0] dwd);
        int first;
        int g;
        int m;
        int nc;
        logic [31:0] ga;
        if (!ri && !rd) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 1'b0);
            check("idle_mem_req", bus.mem_req, 1'b0);
            @(posedge clk);
            #1;
            return;
        end
        if (ri && rd) first = (last_g == 0) ? 1 : 0;
        else          first = rd ? 1 : 0;
        nc = (ri && rd) ? 8 : 4;
        bus.i_req   = ri;
        bus.i_addr  = ia;
        bus.d_req   = rd;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        for (int n = 1; n <= nc; n++) begin
            @(negedge clk);
            g  = (n <= 4) ? first : 1 - first;
            m  = ((n - 1) % 4) + 1;
            ga = (g == 1) ? da : ia;
            check("busy", bus.busy, m != 1);
            check("mem_req", bus.mem_req, m == 2);
            check("i_ready", bus.i_ready, (m == 4) && (g == 0));
            check("d_ready", bus.d_ready, (m == 4) && (g == 1));
`ifdef ARB_TIMEOUT_EN
            check("err_quiet", bus.err, 1'b0);
`endif
            if (m == 2) begin
                check("mem_addr", bus.mem_addr, {ga[31:4], 4'h0});
                check("mem_we", bus.mem_we, (g == 1) && dwe);
                if (g == 1 && dwe) check("mem_wdata", bus.mem_wdata, dwd);
            end
            if (m == 4) begin
                if (g == 0) begin
                    ref_i_rdata = ref_read(ia);
                    check("i_rdata", bus.i_rdata, ref_i_rdata);
                end else if (dwe) begin
                    check("d_rdata_hold", bus.d_rdata, ref_d_rdata);
                    ref_mem[da[7:4]]   = dwd;
                    ref_valid[da[7:4]] = 1'b1;
                end else begin
                    ref_d_rdata = ref_read(da);
                    check("d_rdata", bus.d_rdata, ref_d_rdata);
                end
                last_g = g;
                @(posedge clk);
                #1;
                if (g == 0) bus.i_req = 1'b0;
                else        bus.d_req = 1'b0;
            end
        end
    endtask

    initial begin
        logic [127:0] pat_b;
        int r;
        rst_n       = 1'b0;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        ref_valid   = '0;
        ref_i_rdata = '0;
        ref_d_rdata = '0;
        last_g      = 0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_i_ready", bus.i_ready, 1'b0);
        check("rst_d_ready", bus.d_ready, 1'b0);
        check("rst_mem_addr", bus.mem_addr, '0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_i_rdata", bus.i_rdata, '0);
        check("rst_d_rdata", bus.d_rdata, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // I-cache read of an unaligned address
        do_round(1'b1, 1'b0, 32'h0001_0004, '0, 1'b0, '0);

        // D writeback then D refill of the same line
        pat_b = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
        do_round(1'b0, 1'b1, '0, 32'h0001_0020, 1'b1, pat_b);
        do_round(1'b0, 1'b1, '0, 32'h0001_0020, 1'b0, '0);

        // Reset while waiting on memory
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0001_0050;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t4_wait_busy", bus.busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_abort_busy", bus.busy, 1'b0);
        check("t4_abort_mem_req", bus.mem_req, 1'b0);
        check("t4_abort_i_ready", bus.i_ready, 1'b0);
        check("t4_abort_mem_addr", bus.mem_addr, '0);
        check("t4_abort_i_rdata", bus.i_rdata, '0);
        check("t4_abort_d_rdata", bus.d_rdata, '0);
        bus.i_req   = 1'b0;
        ref_i_rdata = '0;
        ref_d_rdata = '0;
        last_g      = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        spur  = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t4_stale_busy", bus.busy, 1'b0);
            check("t4_stale_i_ready", bus.i_ready, 1'b0);
            check("t4_stale_d_ready", bus.d_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        do_round(1'b1, 1'b0, 32'h0001_0050, '0, 1'b0, '0);

        // Ties: round-robin from a fresh reset history is held by the model
        do_round(1'b1, 1'b1, 32'h0001_0030, 32'h0001_0040, 1'b0, '0);
        do_round(1'b1, 1'b1, 32'h0001_0060, 32'h0001_0070, 1'b0, '0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 3);
            do_round(r[0], r[1], rand_addr(), rand_addr(), 1'($urandom_range(0, 1)), rand_line());
        end
        do_round(1'b0, 1'b1, '0, 32'h0001_0020, 1'b0, '0);

`ifdef ARB_TIMEOUT_EN
        // Silent memory: watchdog ends the transaction with err and a zeroed line
        mem_silent  = 1'b1;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0001_0090;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            check("t5_d_ready", bus.d_ready, n == 11);
            check("t5_err", bus.err, n == 11);
            check("t5_i_ready", bus.i_ready, 1'b0);
            check("t5_busy", bus.busy, (n >= 2) && (n <= 11));
            if (n == 11) begin
                check("t5_d_rdata", bus.d_rdata, '0);
                ref_d_rdata = '0;
                last_g      = 1;
                @(posedge clk);
                #1;
                bus.d_req = 1'b0;
            end
        end
        mem_silent = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
